// File: rtl/lift_pkg.sv
// Shared types and constants for the lift car/shaft plant model.
package lift_pkg;

  typedef enum logic [2:0] {
    ST_AT_FLOOR,
    ST_MOVING,
    ST_OPENING,
    ST_OPEN,
    ST_CLOSING,
    ST_FAULT
  } car_state_t;

  typedef enum logic [1:0] {
    FLT_NONE       = 2'd0,
    OVERTRAVEL     = 2'd1,
    DOOR_IN_MOTION = 2'd2
  } fault_code_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/lift_timer.sv
// Loadable down-counter shared by the travel and door phases.
// expire is high while the count sits at 1, i.e. during the last cycle of a phase.
module lift_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] r_count;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign expire = (r_count == W'(1));

endmodule

// File: rtl/lift_car_plant.sv
// Behavioural lift car/shaft plant: turns controller commands into timed
// floor sensing, door status and a sticky fault report.
module lift_car_plant
  import lift_pkg::*;
#(
  parameter int N_FLOORS      = 12,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 4,
  parameter int START_FLOOR   = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        direction,
  input  logic                        motion,
  input  logic                        door_open,
  output logic [N_FLOORS-1:0]         floor_sense,
  output logic [$clog2(N_FLOORS)-1:0] cur_floor,
  output logic                        door_closed,
  output logic                        door_fully_open,
  output logic                        fault,
  output logic [1:0]                  fault_code
);

  localparam int FW   = $clog2(N_FLOORS);
  localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [N_FLOORS-1:0] ONE        = N_FLOORS'(1);
  localparam logic [N_FLOORS-1:0] RST_SENSE  = ONE << START_FLOOR;
  localparam logic [FW-1:0]       TOP_FLOOR  = FW'(N_FLOORS - 1);
  localparam logic [FW-1:0]       RST_FLOOR  = FW'(START_FLOOR);
  localparam logic [TW-1:0]       TRAVEL_LD  = TW'(TRAVEL_CYCLES);
  localparam logic [TW-1:0]       DOOR_LD    = TW'(DOOR_CYCLES);

  car_state_t          r_state, w_nxt_state;
  logic [FW-1:0]       r_cur_floor, w_nxt_floor;
  logic [N_FLOORS-1:0] r_floor_sense, w_nxt_sense;
  logic                r_door_closed, w_nxt_closed;
  logic                r_door_fully_open, w_nxt_fopen;
  logic                r_dir, w_nxt_dir;
  logic                r_fault;
  fault_code_t         r_fault_code;
  logic                w_flt_req;
  fault_code_t         w_flt_code;
  logic                w_load;
  logic [TW-1:0]       w_load_val;
  logic                w_expire;

  lift_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst_n  (reset),
    .load   (w_load),
    .value  (w_load_val),
    .expire (w_expire)
  );

  // State and registered outputs; a fault freezes everything except the flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state           <= ST_AT_FLOOR;
      r_cur_floor       <= RST_FLOOR;
      r_floor_sense     <= RST_SENSE;
      r_door_closed     <= 1'b1;
      r_door_fully_open <= 1'b0;
      r_dir             <= DIR_UP;
      r_fault           <= 1'b0;
      r_fault_code      <= FLT_NONE;
    end else begin
      r_state           <= w_nxt_state;
      r_cur_floor       <= w_nxt_floor;
      r_floor_sense     <= w_nxt_sense;
      r_door_closed     <= w_nxt_closed;
      r_door_fully_open <= w_nxt_fopen;
      r_dir             <= w_nxt_dir;
      if (w_flt_req) begin
        r_fault      <= 1'b1;
        r_fault_code <= w_flt_code;
      end
    end
  end

  // Next-state, next-output and timer-load decode.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_floor = r_cur_floor;
    w_nxt_sense = r_floor_sense;
    w_nxt_closed = r_door_closed;
    w_nxt_fopen = r_door_fully_open;
    w_nxt_dir   = r_dir;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_flt_req   = 1'b0;
    w_flt_code  = FLT_NONE;
    unique case (r_state)
      ST_AT_FLOOR: begin
        if (motion && door_open) begin
          w_flt_req  = 1'b1;
          w_flt_code = DOOR_IN_MOTION;
        end else if (door_open) begin
          w_nxt_state  = ST_OPENING;
          w_nxt_closed = 1'b0;
          w_load       = 1'b1;
          w_load_val   = DOOR_LD;
        end else if (motion) begin
          if ((direction == DIR_UP && r_cur_floor == TOP_FLOOR) ||
              (direction == DIR_DN && r_cur_floor == '0)) begin
            w_flt_req  = 1'b1;
            w_flt_code = OVERTRAVEL;
          end else begin
            w_nxt_state = ST_MOVING;
            w_nxt_dir   = direction;
            w_nxt_sense = '0;
            w_load      = 1'b1;
            w_load_val  = TRAVEL_LD;
          end
        end
      end
      ST_MOVING: begin
        if (door_open) begin
          w_flt_req  = 1'b1;
          w_flt_code = DOOR_IN_MOTION;
        end else if (w_expire) begin
          w_nxt_floor = (r_dir == DIR_UP) ? r_cur_floor + FW'(1) : r_cur_floor - FW'(1);
          w_nxt_sense = ONE << w_nxt_floor;
          w_nxt_state = ST_AT_FLOOR;
        end
      end
      ST_OPENING: begin
        if (motion) begin
          w_flt_req  = 1'b1;
          w_flt_code = DOOR_IN_MOTION;
        end else if (!door_open) begin
          w_nxt_state = ST_CLOSING;
          w_load      = 1'b1;
          w_load_val  = DOOR_LD;
        end else if (w_expire) begin
          w_nxt_state = ST_OPEN;
          w_nxt_fopen = 1'b1;
        end
      end
      ST_OPEN: begin
        if (motion) begin
          w_flt_req  = 1'b1;
          w_flt_code = DOOR_IN_MOTION;
        end else if (!door_open) begin
          w_nxt_state = ST_CLOSING;
          w_nxt_fopen = 1'b0;
          w_load      = 1'b1;
          w_load_val  = DOOR_LD;
        end
      end
      ST_CLOSING: begin
        if (motion) begin
          w_flt_req  = 1'b1;
          w_flt_code = DOOR_IN_MOTION;
        end else if (door_open) begin
          w_nxt_state = ST_OPENING;
          w_load      = 1'b1;
          w_load_val  = DOOR_LD;
        end else if (w_expire) begin
          w_nxt_state  = ST_AT_FLOOR;
          w_nxt_closed = 1'b1;
        end
      end
      ST_FAULT: begin
        w_nxt_state = ST_FAULT;
      end
      default: begin
        w_nxt_state = ST_FAULT;
      end
    endcase
    if (w_flt_req) begin
      w_nxt_state = ST_FAULT;
    end
  end

  assign floor_sense     = r_floor_sense;
  assign cur_floor       = r_cur_floor;
  assign door_closed     = r_door_closed;
  assign door_fully_open = r_door_fully_open;
  assign fault           = r_fault;
  assign fault_code      = r_fault_code;

endmodule

// File: tb/tb_lift_car_plant.sv
// Self-checking bench for lift_car_plant: directed table, corner sequences,
// and randomized commands against a behavioural car model.
module tb_lift_car_plant;

  logic        clk = 1'b0;
  logic        reset;
  logic        direction, motion, door_open;
  logic [11:0] floor_sense;
  logic [3:0]  cur_floor;
  logic        door_closed, door_fully_open, fault;
  logic [1:0]  fault_code;

  int n_tests = 0;
  int n_fail  = 0;

  lift_car_plant #(
    .N_FLOORS(12), .TRAVEL_CYCLES(16), .DOOR_CYCLES(4), .START_FLOOR(0)
  ) dut (
    .clk(clk), .reset(reset), .direction(direction), .motion(motion),
    .door_open(door_open), .floor_sense(floor_sense), .cur_floor(cur_floor),
    .door_closed(door_closed), .door_fully_open(door_fully_open),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1);
  end

  // Behavioural car: hop countdown, door stroke countdown, sticky fault.
  int m_floor, m_hop, m_stroke, m_code;
  bit m_up, m_opening, m_full_open, m_closed, m_fault;

  task automatic model_reset();
    m_floor = 0; m_hop = 0; m_stroke = 0; m_code = 0;
    m_up = 1'b0; m_opening = 1'b0; m_full_open = 1'b0; m_closed = 1'b1; m_fault = 1'b0;
  endtask

  task automatic model_fault(input int code);
    m_fault = 1'b1;
    m_code  = code;
  endtask

  task automatic model_step(input bit mo, input bit di, input bit dop);
    if (m_fault) return;
    if (m_hop > 0) begin
      if (dop) model_fault(2);
      else begin
        m_hop--;
        if (m_hop == 0) m_floor += m_up ? 1 : -1;
      end
    end else if (!m_closed) begin
      if (mo) model_fault(2);
      else if (m_full_open) begin
        if (!dop) begin m_full_open = 1'b0; m_opening = 1'b0; m_stroke = 4; end
      end else if (m_opening) begin
        if (!dop) begin m_opening = 1'b0; m_stroke = 4; end
        else begin m_stroke--; if (m_stroke == 0) m_full_open = 1'b1; end
      end else begin
        if (dop) begin m_opening = 1'b1; m_stroke = 4; end
        else begin m_stroke--; if (m_stroke == 0) m_closed = 1'b1; end
      end
    end else begin
      if (mo && dop) model_fault(2);
      else if (dop) begin m_closed = 1'b0; m_opening = 1'b1; m_stroke = 4; end
      else if (mo) begin
        if ((di && m_floor == 11) || (!di && m_floor == 0)) model_fault(1);
        else begin m_hop = 16; m_up = di; end
      end
    end
  endtask

  function automatic logic [20:0] pack(input logic [11:0] fs, input logic [3:0] cf,
                                       input logic dc, input logic fo, input logic f,
                                       input logic [1:0] code);
    return {fs, cf, dc, fo, f, code};
  endfunction

  function automatic logic [20:0] mexp();
    logic [11:0] one;
    logic [11:0] fs;
    one = 12'h001;
    fs  = (m_hop > 0) ? 12'h000 : (one << m_floor);
    return pack(fs, 4'(m_floor), m_closed, m_full_open, m_fault, 2'(m_code));
  endfunction

  task automatic check_vec(input string nm, input logic [20:0] exp);
    logic [20:0] got;
    got = pack(floor_sense, cur_floor, door_closed, door_fully_open, fault, fault_code);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got fs=%h cf=%0d dc=%b fo=%b f=%b code=%0d, expected fs=%h cf=%0d dc=%b fo=%b f=%b code=%0d",
               nm, got[20:9], got[8:5], got[4], got[3], got[2], got[1:0],
               exp[20:9], exp[8:5], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  // One clock: drive at negedge, advance model, sample 1ns after posedge.
  task automatic tick(input bit mo, input bit di, input bit dop);
    @(negedge clk);
    motion = mo; direction = di; door_open = dop;
    model_step(mo, di, dop);
    @(posedge clk);
    #1;
  endtask

  // Async assert between edges; outputs must already be at reset values.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b0; motion = 1'b0; direction = 1'b0; door_open = 1'b0;
    model_reset();
    #1;
    check_vec("async_reset", pack(12'h001, 4'd0, 1'b1, 1'b0, 1'b0, 2'd0));
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    bit          mo, di, dop;
    int unsigned n;
    logic [11:0] fs;
    logic [3:0]  cf;
    logic        dc, fo, f;
    logic [1:0]  code;
  } vec_t;

  vec_t vecs[15];

  initial begin
    bit dreq;
    int dwell;
    reset = 1'b0; motion = 1'b0; direction = 1'b0; door_open = 1'b0;
    model_reset();

    vecs[0]  = '{0,0,0, 1, 12'h001, 4'd0, 1,0,0, 2'd0};
    vecs[1]  = '{1,1,0, 1, 12'h000, 4'd0, 1,0,0, 2'd0};
    vecs[2]  = '{0,1,0,14, 12'h000, 4'd0, 1,0,0, 2'd0};
    vecs[3]  = '{0,0,0, 1, 12'h000, 4'd0, 1,0,0, 2'd0};
    vecs[4]  = '{0,0,0, 1, 12'h002, 4'd1, 1,0,0, 2'd0};
    vecs[5]  = '{0,0,1, 1, 12'h002, 4'd1, 0,0,0, 2'd0};
    vecs[6]  = '{0,0,1, 3, 12'h002, 4'd1, 0,0,0, 2'd0};
    vecs[7]  = '{0,0,1, 1, 12'h002, 4'd1, 0,1,0, 2'd0};
    vecs[8]  = '{0,0,0, 1, 12'h002, 4'd1, 0,0,0, 2'd0};
    vecs[9]  = '{0,0,0, 3, 12'h002, 4'd1, 0,0,0, 2'd0};
    vecs[10] = '{0,0,0, 1, 12'h002, 4'd1, 1,0,0, 2'd0};
    vecs[11] = '{1,0,0, 1, 12'h000, 4'd1, 1,0,0, 2'd0};
    vecs[12] = '{0,0,0,16, 12'h001, 4'd0, 1,0,0, 2'd0};
    vecs[13] = '{1,0,0, 1, 12'h001, 4'd0, 1,0,1, 2'd1};
    vecs[14] = '{0,0,1, 3, 12'h001, 4'd0, 1,0,1, 2'd1};

    repeat (2) @(negedge clk);
    #1;
    check_vec("reset_state", pack(12'h001, 4'd0, 1'b1, 1'b0, 1'b0, 2'd0));
    @(negedge clk);
    reset = 1'b1;

    for (int unsigned i = 0; i < 15; i++) begin
      repeat (vecs[i].n) tick(vecs[i].mo, vecs[i].di, vecs[i].dop);
      check_vec($sformatf("vec%0d", i),
                pack(vecs[i].fs, vecs[i].cf, vecs[i].dc, vecs[i].fo, vecs[i].f, vecs[i].code));
    end

    // Door request at cycle 8 of a hop.
    do_reset();
    tick(1, 1, 0);
    repeat (7) tick(0, 1, 0);
    check_vec("hop_mid", pack(12'h000, 4'd0, 1'b1, 1'b0, 1'b0, 2'd0));
    tick(0, 1, 1);
    check_vec("door_in_hop", pack(12'h000, 4'd0, 1'b1, 1'b0, 1'b1, 2'd2));
    repeat (20) tick(0, 1, 0);
    check_vec("door_in_hop_held", pack(12'h000, 4'd0, 1'b1, 1'b0, 1'b1, 2'd2));

    // Motion dropped and direction flipped mid-hop: hop still completes upward.
    do_reset();
    tick(1, 1, 0);
    repeat (15) tick(0, 0, 0);
    check_vec("flip_before", pack(12'h000, 4'd0, 1'b1, 1'b0, 1'b0, 2'd0));
    tick(0, 0, 0);
    check_vec("flip_arrive", pack(12'h002, 4'd1, 1'b1, 1'b0, 1'b0, 2'd0));

    // Climb to the top floor, then request one more floor up.
    do_reset();
    for (int unsigned h = 0; h < 11; h++) begin
      tick(1, 1, 0);
      repeat (16) tick(0, 0, 0);
    end
    check_vec("top_floor", pack(12'h800, 4'd11, 1'b1, 1'b0, 1'b0, 2'd0));
    tick(1, 1, 0);
    check_vec("overtravel_up", pack(12'h800, 4'd11, 1'b1, 1'b0, 1'b1, 2'd1));
    tick(0, 0, 1);
    check_vec("overtravel_held", pack(12'h800, 4'd11, 1'b1, 1'b0, 1'b1, 2'd1));
    do_reset();

    // Randomized commands against the model.
    dreq  = 1'b0;
    dwell = 0;
    for (int unsigned c = 0; c < 4000; c++) begin
      if (m_fault) dwell++;
      if ((m_fault && dwell > 5) || $urandom_range(0, 499) == 0) begin
        do_reset();
        dwell = 0;
        dreq  = 1'b0;
      end else begin
        bit mo;
        if ($urandom_range(0, 23) == 0) dreq = ~dreq;
        mo = ($urandom_range(0, 9) == 0) && (!dreq || $urandom_range(0, 7) == 0);
        tick(mo, 1'($urandom_range(0, 1)), dreq);
        check_vec("rand", mexp());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
